imm_encode: RTL and testbench

IMM_ENCODE -- requirements
Module: imm_encode

---
 rtl/imm_encode.sv | 138 +++++++++++++
 tb/tb_imm_encode.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// Immediate encoder: packs a 32-bit immediate into RISC-V instruction bits [31:7]
// for the I/S/B/U/J formats and flags values the chosen format cannot represent.
module imm_encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ImmSrc,
  input  logic [31:0] imm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] imm_field,
  output logic        imm_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_U = 3'd3;
  localparam logic [2:0] SRC_J = 3'd4;

  // Handshake: a side transfers on any cycle where its valid and ready are both high.
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_src_q, s1_src_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic        s1_err_q, s1_err_d;
  logic        out_valid_q, out_valid_d;
  logic [24:0] imm_field_q, imm_field_d;
  logic        imm_err_q, imm_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        chk_err;
  logic [24:0] pack_field;

  // Representability is judged on the raw request so S2 only has to pack.
  always_comb begin
    chk_err = 1'b1;
    case (ImmSrc)
      SRC_I, SRC_S: chk_err = !((&imm_in[31:11]) || (~|imm_in[31:11]));
      SRC_B:        chk_err = !((&imm_in[31:12]) || (~|imm_in[31:12])) || imm_in[0];
      SRC_U:        chk_err = |imm_in[11:0];
      SRC_J:        chk_err = !((&imm_in[31:20]) || (~|imm_in[31:20])) || imm_in[0];
      default:      chk_err = 1'b1;
    endcase
  end

  // Field bit k corresponds to instruction bit k+7.
  always_comb begin
    pack_field = '0;
    case (s1_src_q)
      SRC_I: pack_field[24:13] = s1_imm_q[11:0];
      SRC_S: begin
        pack_field[24:18] = s1_imm_q[11:5];
        pack_field[4:0]   = s1_imm_q[4:0];
      end
      SRC_B: begin
        pack_field[24]    = s1_imm_q[12];
        pack_field[23:18] = s1_imm_q[10:5];
        pack_field[4:1]   = s1_imm_q[4:1];
        pack_field[0]     = s1_imm_q[11];
      end
      SRC_U: pack_field[24:5] = s1_imm_q[31:12];
      SRC_J: begin
        pack_field[24]    = s1_imm_q[20];
        pack_field[23:14] = s1_imm_q[10:1];
        pack_field[13]    = s1_imm_q[11];
        pack_field[12:5]  = s1_imm_q[19:12];
      end
      default: pack_field = '0;
    endcase
  end

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_valid_d  = s1_valid_q;
    s1_src_d    = s1_src_q;
    s1_imm_d    = s1_imm_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    imm_field_d = imm_field_q;
    imm_err_d   = imm_err_q;
    err_count_d = err_count_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_src_d = ImmSrc;
        s1_imm_d = imm_in;
        s1_err_d = chk_err;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        imm_field_d = pack_field;
        imm_err_d   = s1_err_q;
      end
    end

    if (out_valid_q && out_ready && imm_err_q && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_src_q    <= '0;
      s1_imm_q    <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      imm_field_q <= '0;
      imm_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_src_q    <= s1_src_d;
      s1_imm_q    <= s1_imm_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      imm_field_q <= imm_field_d;
      imm_err_q   <= imm_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign imm_field = imm_field_q;
  assign imm_err   = imm_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed vectors, back-pressure, saturation and reset,
// then randomized traffic scored against a value-range reference model.
module tb_imm_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [31:0] imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] imm_field;
  logic        imm_err;
  logic [7:0]  err_count;

  imm_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (imm_src),
    .imm_in    (imm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_field (imm_field),
    .imm_err   (imm_err),
    .err_count (err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;

  // {src[60:58], imm[57:26], field[25:1], err[0]}
  logic [60:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [2:0] s, input logic [31:0] d);
    int v;
    v = $signed(d);
    case (s)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (v < -4096) || (v > 4095) || ((v % 2) != 0);
      3'd3:       return (d % 4096) != 0;
      3'd4:       return (v < -1048576) || (v > 1048575) || ((v % 2) != 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [24:0] model_field(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0;
    case (s)
      3'd0: w[31:20] = d[11:0];
      3'd1: begin w[31:25] = d[11:5]; w[11:7] = d[4:0]; end
      3'd2: begin w[31] = d[12]; w[30:25] = d[10:5]; w[11:8] = d[4:1]; w[7] = d[11]; end
      3'd3: w[31:12] = d[31:12];
      3'd4: begin w[31] = d[20]; w[30:21] = d[10:1]; w[20] = d[11]; w[19:12] = d[19:12]; end
      default: w = 32'h0;
    endcase
    return 25'(w >> 7);
  endfunction

  // Sign-extending decode, as an instruction decoder would see the field.
  function automatic logic [31:0] decode(input logic [2:0] s, input logic [24:0] f);
    case (s)
      3'd0: return {{20{f[24]}}, f[24:13]};
      3'd1: return {{20{f[24]}}, f[24:18], f[4:0]};
      3'd2: return {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
      3'd3: return {f[24:5], 12'h000};
      3'd4: return {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [2:0] s, input logic [31:0] d, input bit ordy,
                      input bit use_c, input logic [31:0] c_word, input bit c_err, output bit acc);
    logic [24:0] f;
    logic        e;
    @(negedge clk);
    in_valid  = v;
    imm_src   = s;
    imm_in    = d;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      f = use_c ? c_word[31:7] : model_field(s, d);
      e = use_c ? c_err : model_err(s, d);
      exp_q.push_back({s, d, f, e});
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 3'd0, 32'h0, ordy, 1'b0, 32'h0, 1'b0, acc);
  endtask

  task automatic send(input logic [2:0] s, input logic [31:0] d,
                      input bit use_c, input logic [31:0] c_word, input bit c_err);
    bit acc;
    int b;
    acc = 1'b0;
    b = 0;
    while (!acc && b < 200) begin
      step(1'b1, s, d, 1'b1, use_c, c_word, c_err, acc);
      b++;
    end
    if (!acc) chk("send_timeout", 32'(b), 32'(0));
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      idle(1'b1);
      b++;
    end
    idle(1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [60:0] e;
    bit          hold;
    logic [24:0] h_field;
    logic        h_err;
    hold = 1'b0;
    h_field = '0;
    h_err = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
        mdl_cnt = 0;
      end else begin
        if (hold) begin
          chk("stall_valid", 32'(out_valid), 32'(1));
          chk("stall_field", 32'(imm_field), 32'(h_field));
          chk("stall_err", 32'(imm_err), 32'(h_err));
        end
        chk("err_count", 32'(err_count), 32'(mdl_cnt));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("imm_field", 32'(imm_field), 32'(e[25:1]));
            chk("imm_err", 32'(imm_err), 32'(e[0]));
            if (!imm_err) chk("round_trip", decode(e[60:58], imm_field), e[57:26]);
            if (e[0] && mdl_cnt < 255) mdl_cnt++;
          end
        end
        hold = out_valid && !out_ready;
        h_field = imm_field;
        h_err = imm_err;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int n;
    int idx;
    int b;
    int sent;
    bit pend;
    logic [2:0]  rs;
    logic [31:0] rd;

    rst_n = 1'b0;
    in_valid = 1'b0;
    imm_src = 3'd0;
    imm_in = 32'h0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_imm_field", 32'(imm_field), 32'(0));
    chk("rst_imm_err", 32'(imm_err), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    repeat (2) @(negedge clk);
    #4 rst_n = 1'b1;
    idle(1'b1);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Directed vectors with hand-computed instruction words.
    send(3'd0, 32'hFFFFF800, 1'b1, 32'h80000000, 1'b0);
    send(3'd0, 32'h00000800, 1'b1, 32'h80000000, 1'b1);
    drain();
    chk("i_err_count", 32'(err_count), 32'(1));
    send(3'd2, 32'h00000FFE, 1'b1, 32'h7E000F80, 1'b0);
    send(3'd2, 32'h00000FFF, 1'b1, 32'h7E000F80, 1'b1);
    send(3'd3, 32'h12345000, 1'b1, 32'h12345000, 1'b0);
    send(3'd4, 32'hFFF00000, 1'b1, 32'h80000000, 1'b0);
    send(3'd1, 32'hFFFFF7FF, 1'b1, 32'h7E000F80, 1'b1);
    send(3'd1, 32'h000007E5, 1'b1, 32'h7E000280, 1'b0);
    drain();
    chk("b_err_count", 32'(err_count), 32'(3));

    // Latency: result visible exactly two cycles after acceptance.
    send(3'd0, 32'h00000005, 1'b0, 32'h0, 1'b0);
    n = 0;
    b = 0;
    while (!out_valid && b < 10) begin
      idle(1'b1);
      n++;
      b++;
    end
    chk("latency", 32'(n), 32'(2));
    drain();

    // Throughput: back-to-back acceptance with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i % 5), $urandom_range(0, 4095), 1'b1, 1'b0, 32'h0, 1'b0, acc);
      chk("throughput_acc", 32'(acc), 32'(1));
    end
    drain();

    // Back-pressure: two slots only, order kept after release.
    idx = 0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 3'd0, 32'h10 + 32'(idx), 1'b0, 1'b0, 32'h0, 1'b0, acc);
      if (acc) begin idx++; n++; end
    end
    chk("stall_accepted", 32'(n), 32'(2));
    chk("stall_in_ready", 32'(in_ready), 32'(0));
    b = 0;
    while (idx < 4 && b < 50) begin
      step(1'b1, 3'd0, 32'h10 + 32'(idx), 1'b1, 1'b0, 32'h0, 1'b0, acc);
      if (acc) idx++;
      b++;
    end
    chk("stall_all_sent", 32'(idx), 32'(4));
    drain();

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(5, 7)), $urandom, 1'b0, 32'h0, 1'b0);
    end
    drain();
    chk("err_count_sat", 32'(err_count), 32'(255));

    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++) send(3'd5, 32'(i), 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_err_count", 32'(err_count), 32'(0));
    chk("midrst_imm_field", 32'(imm_field), 32'(0));
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    #5 rst_n = 1'b1;
    idle(1'b1);
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_no_output", 32'(out_valid), 32'(0));

    // Randomized traffic with random back-pressure.
    sent = 0;
    pend = 1'b0;
    rs = 3'd0;
    rd = 32'h0;
    b = 0;
    while (sent < 10000 && b < 60000) begin
      if (!pend && $urandom_range(0, 4) != 0) begin
        rs = 3'($urandom_range(0, 4));
        case ($urandom_range(0, 3))
          0: rd = $urandom;
          1: rd = 32'($urandom_range(0, 8191)) - 32'd4096;
          2: rd = 32'($urandom_range(0, 2097151)) - 32'd1048576;
          default: rd = $urandom & 32'hFFFFF000;
        endcase
        if ($urandom_range(0, 1) == 0) rd[0] = 1'b0;
        pend = 1'b1;
      end
      step(pend, rs, rd, $urandom_range(0, 3) != 0, 1'b0, 32'h0, 1'b0, acc);
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
      b++;
    end
    chk("random_all_sent", 32'(sent), 32'(10000));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
